// File: rtl/seqdet_pkg.sv
// Shared types and constants for the pattern sequence detector.
package seqdet_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ARMED
    } state_t;

    // Legacy 8 x 3-bit pattern; element 0 (matched first) sits in the LSBs.
    localparam logic [23:0] SEQDET_DEFAULT_PAT = 24'b101_011_110_110_000_110_101_001;

    function automatic int fill_width(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/seqdet_window.sv
// Symbol shift register plus occupancy counter for the detector window.
module seqdet_window #(
    parameter int SYM_W   = 3,
    parameter int SEQ_LEN = 8,
    parameter int FILL_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift,
    input  logic                     flush,
    input  logic [SYM_W-1:0]         data,
    output logic [SEQ_LEN*SYM_W-1:0] window,
    output logic [FILL_W-1:0]        fill
);

    localparam int VEC_W = SEQ_LEN * SYM_W;
    localparam logic [FILL_W-1:0] FULL = FILL_W'(SEQ_LEN);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window <= '0;
            fill   <= '0;
        end else begin
            // Newest symbol enters at the top element; element 0 is the oldest.
            if (shift) begin
                window <= {data, window[VEC_W-1:SYM_W]};
            end
            if (flush) begin
                fill <= '0;
            end else if (shift && fill != FULL) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_seq_detector.sv
// Runtime-programmable sliding-window symbol sequence detector.
// Define SEQDET_OVERLAP_EN to keep the window after a match (overlapping detection).
module pattern_seq_detector
    import seqdet_pkg::*;
#(
    parameter int                         SYM_W    = 3,
    parameter int                         SEQ_LEN  = 8,
    parameter int                         CNT_W    = 8,
    parameter logic [SEQ_LEN*SYM_W-1:0]   PAT_INIT = SEQDET_DEFAULT_PAT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           valid_i,
    input  logic [SYM_W-1:0]               data_i,
    input  logic                           pat_wr_en,
    input  logic [$clog2(SEQ_LEN)-1:0]     pat_wr_idx,
    input  logic [SYM_W-1:0]               pat_wr_data,
    input  logic                           clear_i,
    output logic                           match_o,
    output logic                           match_sticky_o,
    output logic [CNT_W-1:0]               match_count_o,
    output logic [fill_width(SEQ_LEN)-1:0] fill_o
);

    localparam int IDX_W  = $clog2(SEQ_LEN);
    localparam int FILL_W = fill_width(SEQ_LEN);
    localparam int VEC_W  = SEQ_LEN * SYM_W;
    localparam logic [FILL_W-1:0] FULL    = FILL_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
`ifdef SEQDET_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   pat_q;
    logic [VEC_W-1:0]   window;
    logic [VEC_W-1:0]   post_window;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  post_fill;
    logic               idx_ok, wr_hit, accept, match, shift, flush;

    if ((1 << IDX_W) == SEQ_LEN) begin : g_idx_full
        assign idx_ok = 1'b1;
    end else begin : g_idx_range
        assign idx_ok = ({1'b0, pat_wr_idx} < (IDX_W + 1)'(SEQ_LEN));
    end

    assign wr_hit      = pat_wr_en & idx_ok;
    assign accept      = en & valid_i & ~pat_wr_en;
    assign post_window = {data_i, window[VEC_W-1:SYM_W]};
    assign post_fill   = (fill == FULL) ? FULL : fill + 1'b1;
    assign match       = accept && (post_fill == FULL) && (post_window == pat_q);

    // NOTE: the pattern registers are reset because PAT_INIT must be live straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= PAT_INIT;
        end else if (wr_hit) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                if (pat_wr_idx == IDX_W'(i)) begin
                    pat_q[i*SYM_W +: SYM_W] <= pat_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        shift   = 1'b0;
        flush   = 1'b0;
        if (!en) begin
            state_d = IDLE;
            flush   = 1'b1;
        end else if (wr_hit) begin
            state_d = FILL;
            flush   = 1'b1;
        end else if (accept) begin
            shift = 1'b1;
            if (match && !OVERLAP) begin
                state_d = FILL;
                flush   = 1'b1;
            end else begin
                state_d = (post_fill == FULL) ? ARMED : FILL;
            end
        end else if (state_q == IDLE) begin
            state_d = FILL;
        end
    end

    seqdet_window #(
        .SYM_W   (SYM_W),
        .SEQ_LEN (SEQ_LEN),
        .FILL_W  (FILL_W)
    ) u_window (
        .clk    (clk),
        .reset  (reset),
        .shift  (shift),
        .flush  (flush),
        .data   (data_i),
        .window (window),
        .fill   (fill)
    );

    // A match coincident with clear_i wins: the count restarts at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_o        <= 1'b0;
            match_sticky_o <= 1'b0;
            match_count_o  <= '0;
        end else begin
            match_o <= match;
            if (match) begin
                match_sticky_o <= 1'b1;
                if (clear_i) begin
                    match_count_o <= CNT_W'(1);
                end else if (match_count_o != CNT_MAX) begin
                    match_count_o <= match_count_o + 1'b1;
                end
            end else if (clear_i) begin
                match_sticky_o <= 1'b0;
                match_count_o  <= '0;
            end
        end
    end

    assign fill_o = fill;

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Scoreboard bench for pattern_seq_detector (main instance plus a CNT_W=2 instance).
module tb_pattern_seq_detector;
    import seqdet_pkg::*;

`ifdef SEQDET_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif
    localparam int FILL_AFTER  = OVERLAP ? 8 : 0;
    localparam int FILL_AFTER2 = OVERLAP ? 2 : 0;

    typedef struct {
        int cnt;
        int fill;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic reset;
    logic en, valid_i, pat_wr_en, clear_i;
    logic [2:0] data_i, pat_wr_idx, pat_wr_data;
    logic match_o, match_sticky_o;
    logic [7:0] match_count_o;
    logic [3:0] fill_o;

    logic b_en, b_valid, b_data, b_wr, b_idx, b_wdata, b_clear;
    logic b_match, b_sticky;
    logic [1:0] b_count, b_fill;

    logic [2:0] def_seq [8] = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};

    always #5 clk = ~clk;

    pattern_seq_detector #(.SYM_W(3), .SEQ_LEN(8), .CNT_W(8), .PAT_INIT(SEQDET_DEFAULT_PAT)) dut (
        .clk(clk), .reset(reset), .en(en), .valid_i(valid_i), .data_i(data_i),
        .pat_wr_en(pat_wr_en), .pat_wr_idx(pat_wr_idx), .pat_wr_data(pat_wr_data),
        .clear_i(clear_i), .match_o(match_o), .match_sticky_o(match_sticky_o),
        .match_count_o(match_count_o), .fill_o(fill_o)
    );

    pattern_seq_detector #(.SYM_W(1), .SEQ_LEN(2), .CNT_W(2), .PAT_INIT(2'b11)) dut2 (
        .clk(clk), .reset(reset), .en(b_en), .valid_i(b_valid), .data_i(b_data),
        .pat_wr_en(b_wr), .pat_wr_idx(b_idx), .pat_wr_data(b_wdata),
        .clear_i(b_clear), .match_o(b_match), .match_sticky_o(b_sticky),
        .match_count_o(b_count), .fill_o(b_fill)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic v, input logic [2:0] d, input logic w,
                       input logic [2:0] wi, input logic [2:0] wd, input logic c);
        @(negedge clk);
        en = e; valid_i = v; data_i = d;
        pat_wr_en = w; pat_wr_idx = wi; pat_wr_data = wd; clear_i = c;
    endtask

    task automatic sym(input logic [2:0] d);
        cyc(1'b1, 1'b1, d, 1'b0, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic bcyc(input logic v, input logic d, input logic c);
        @(negedge clk);
        b_valid = v; b_data = d; b_clear = c;
    endtask

    // Monitors: every match pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (match_o) begin
            if (q1.size() == 0) begin
                check("dut_unexpected_match", match_o, 0);
            end else begin
                e1 = q1.pop_front();
                check("dut_match_count", match_count_o, e1.cnt);
                check("dut_match_sticky", match_sticky_o, 1);
                check("dut_match_fill", fill_o, e1.fill);
            end
        end
    end

    always @(negedge clk) begin
        if (b_match) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_match", b_match, 0);
            end else begin
                e2 = q2.pop_front();
                check("dut2_match_count", b_count, e2.cnt);
                check("dut2_match_sticky", b_sticky, 1);
                check("dut2_match_fill", b_fill, e2.fill);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nm;
        reset = 1'b1;
        en = 1'b0; valid_i = 1'b0; data_i = '0; pat_wr_en = 1'b0;
        pat_wr_idx = '0; pat_wr_data = '0; clear_i = 1'b0;
        b_en = 1'b1; b_valid = 1'b0; b_data = 1'b0; b_wr = 1'b0;
        b_idx = 1'b0; b_wdata = 1'b0; b_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_match", match_o, 0);
        check("reset_sticky", match_sticky_o, 0);
        check("reset_count", match_count_o, 0);
        check("reset_fill", fill_o, 0);
        reset = 1'b0;

        // Default pattern, contiguous stream.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) q1.push_back('{1, FILL_AFTER});
            sym(def_seq[i]);
        end
        idle(2);
        check("contig_count", match_count_o, 1);
        check("contig_sticky", match_sticky_o, 1);
        check("contig_pulse_done", match_o, 0);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        idle(1);
        check("clear_count", match_count_o, 0);
        check("clear_sticky", match_sticky_o, 0);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        idle(1);
        check("disable_fill", fill_o, 0);

        // Same stream with 3-cycle valid gaps.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) q1.push_back('{1, FILL_AFTER});
            sym(def_seq[i]);
            if (i < 7) idle(3);
        end
        idle(2);
        check("gap_count", match_count_o, 1);
        check("gap_sticky", match_sticky_o, 1);

        // Program all-110 (clearing the count on the first write), then 9 x 110.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 3'd0, 1'b1, 3'(i), 3'b110, i == 0);
        end
        idle(1);
        check("write_fill", fill_o, 0);
        check("write_clear_count", match_count_o, 0);
        for (int k = 0; k < 9; k++) begin
            if (k == 7) q1.push_back('{1, FILL_AFTER});
            if (k == 8 && OVERLAP) q1.push_back('{2, 8});
            sym(3'b110);
        end
        idle(2);
        check("all110_count", match_count_o, OVERLAP ? 2 : 1);

        // Pattern write with a coincident valid symbol: the symbol is dropped.
        cyc(1'b1, 1'b1, 3'b110, 1'b1, 3'd0, 3'b110, 1'b0);
        idle(1);
        check("wr_valid_fill", fill_o, 0);
        for (int k = 0; k < 7; k++) sym(3'b110);
        idle(1);
        check("wr_valid_fill7", fill_o, 7);
        q1.push_back('{1, FILL_AFTER});
        cyc(1'b1, 1'b1, 3'b110, 1'b0, 3'd0, 3'd0, 1'b1);
        idle(1);
        check("clear_vs_match_count", match_count_o, 1);
        check("clear_vs_match_sticky", match_sticky_o, 1);
        idle(1);

        // Asynchronous reset mid-window, then restored default pattern.
        for (int i = 0; i < 5; i++) sym(def_seq[i]);
        @(posedge clk);
        #2 reset = 1'b1;
        valid_i = 1'b0;
        #1;
        check("async_reset_match", match_o, 0);
        check("async_reset_sticky", match_sticky_o, 0);
        check("async_reset_count", match_count_o, 0);
        check("async_reset_fill", fill_o, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 5; i < 8; i++) sym(def_seq[i]);
        idle(1);
        check("post_reset_fill", fill_o, 3);
        check("post_reset_count", match_count_o, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) q1.push_back('{1, FILL_AFTER});
            sym(def_seq[i]);
        end
        idle(2);
        check("restored_pat_count", match_count_o, 1);

        // CNT_W=2 instance, pattern 1,1 on a stream of ones.
        nm = 0;
        for (int k = 1; k <= 3; k++) begin
            if (OVERLAP ? (k >= 2) : (k % 2 == 0)) begin
                nm++;
                q2.push_back('{(nm > 3) ? 3 : nm, FILL_AFTER2});
            end
            bcyc(1'b1, 1'b1, 1'b0);
        end
        bcyc(1'b0, 1'b0, 1'b0);
        bcyc(1'b0, 1'b0, 1'b0);
        check("overlap_example_count", b_count, OVERLAP ? 2 : 1);
        for (int k = 4; k <= (OVERLAP ? 6 : 10); k++) begin
            if (OVERLAP ? (k >= 2) : (k % 2 == 0)) begin
                nm++;
                q2.push_back('{(nm > 3) ? 3 : nm, FILL_AFTER2});
            end
            bcyc(1'b1, 1'b1, 1'b0);
        end
        bcyc(1'b0, 1'b0, 1'b0);
        bcyc(1'b0, 1'b0, 1'b0);
        check("saturate_count", b_count, 3);
        check("saturate_sticky", b_sticky, 1);
        bcyc(1'b0, 1'b0, 1'b1);
        bcyc(1'b0, 1'b0, 1'b0);
        check("sat_clear_count", b_count, 0);
        check("sat_clear_sticky", b_sticky, 0);

        check("dut_queue_drained", q1.size(), 0);
        check("dut2_queue_drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_seq_detector.md
# pattern_seq_detector

Parametrised, runtime-programmable symbol-sequence detector for the stream-monitoring path. It accepts one SYM_W-bit symbol per valid cycle and compares a sliding window of the last SEQ_LEN symbols against a pattern held in writable registers. On each match it produces a registered single-cycle pulse, a sticky flag and a saturating match count. It replaces fixed-pattern, fixed-width detectors with one block that also offers a selectable overlap mode.

## Interface
- SYM_W, 3: symbol width in bits (≥1).
- SEQ_LEN, 8: pattern length in symbols (2..32).
- CNT_W, 8: match counter width.
- PAT_INIT, packed SEQ_LEN*SYM_W: reset pattern; element i at [i*SYM_W +: SYM_W], element 0 matched first. Default is 001,101,110,000,110,110,011,101.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  detector enable.
- valid_i  in  1  data_i carries a symbol this cycle.
- data_i  in  SYM_W  input symbol.
- pat_wr_en  in  1  write one pattern element.
- pat_wr_idx  in  $clog2(SEQ_LEN)  element index.
- pat_wr_data  in  SYM_W  element value.
- clear_i  in  1  clear count and sticky flag.
- match_o  out  1  one-cycle match pulse.
- match_sticky_o  out  1  set on match, held until clear_i.
- match_count_o  out  CNT_W  saturating match count.
- fill_o  out  $clog2(SEQ_LEN+1)  symbols currently in window.

## Operation
- State machine (seqdet_pkg::state_t):
  - IDLE: en=0. Window fill is 0 and symbols are ignored. Moves to FILL when en=1.
  - FILL: fill<SEQ_LEN. Each accepted symbol shifts into the window and increments fill. Moves to ARMED when fill reaches SEQ_LEN.
  - ARMED: each accepted symbol shifts in and the oldest symbol drops out.
  - From any state, en=0 returns to IDLE and clears fill.
- Accepted symbol: en=1, valid_i=1 and pat_wr_en=0.
- Match: on an accepted symbol, the post-shift window equals the pattern element-wise and the post-shift fill equals SEQ_LEN.
- A match registers match_o=1 for one cycle, sets match_sticky_o, and increments match_count_o, saturating at 2^CNT_W−1.
- Pattern write (any state):
  - Writes pattern[pat_wr_idx] and forces fill to 0. If en=1 the state becomes FILL.
  - A valid_i in the same cycle is discarded.
  - pat_wr_idx ≥ SEQ_LEN: write ignored, fill unaffected.
- clear_i zeroes the count and the sticky flag. If a match occurs in the same cycle, the match wins: count=1, sticky=1, match_o=1.
- Reset (asynchronous, any time including mid-window):
  - state IDLE, fill 0, window 0, pattern=PAT_INIT.
  - match_o=0, match_sticky_o=0, match_count_o=0, fill_o=0.

## Timing
- match_o asserts in the cycle after the clock edge that accepts the final symbol. Latency is 1 clk from the valid_i sample.
- Back-to-back matches produce back-to-back pulses with no dead cycle.
- fill_o, match_sticky_o and match_count_o are registered and update on the same edge as match_o.
- A pattern write takes effect for the next accepted symbol. The minimum time to the first match after a write is SEQ_LEN accepted symbols.
- Gaps in valid_i are transparent: the window holds its contents.

## Configuration
- SEQDET_OVERLAP_EN defined: the window is kept after a match, so overlapping occurrences are detected. Example: pattern 1,1 on stream 1,1,1 gives 2 matches.
- SEQDET_OVERLAP_EN undefined: a match forces fill to 0 and the state to FILL, so only non-overlapping occurrences are detected. The same example gives 1 match.

## Structure
- seqdet_pkg holds:
  - state_t enum (IDLE, FILL, ARMED).
  - SEQDET_DEFAULT_PAT constant (legacy 8×3-bit pattern).
  - Helper function for the width of fill_o.
- Sub-module seqdet_window contains the shift register and fill counter. Its inputs are shift and flush; its outputs are the window vector and fill.
- The top level contains the pattern registers, the comparator, the FSM, and the count/sticky logic.

## Test plan
- Default pattern; stream 001,101,110,000,110,110,011,101 with contiguous valid → one match_o pulse 1 clk after the last symbol; count=1; sticky=1.
- Same stream with valid_i gaps of 3 cycles between symbols → identical single match.
- Write pattern all-110 at SEQ_LEN=8; feed 9×110:
  - overlap build: 2 matches, count=2.
  - non-overlap build: 1 match, count=1.
- Assert reset after 5 correct symbols, then feed the remaining 3 → no match; fill_o=3; all outputs 0 immediately after reset.
- Pattern write in the same cycle as a valid symbol → symbol discarded, fill_o=0. clear_i coincident with a match → count=1, sticky=1.
- CNT_W=2; feed 5 matches → count saturates at 3; clear_i → count 0, sticky 0.
